orientation_finder: RTL and testbench

- Inverse of the on-screen rover marker renderer: it recovers position and heading from the camera pixel stream, where the renderer draws them.
- Over each frame it classifies pixels as body colour or indicator colour and accumulates coordinate sums.
- At frame end it computes both centroids with a sequential divider, then quantises the body-to-indicator vector to one of 24 headings (15° steps).
- Sits between the camera capture front end and the navigation/display logic. Orientation encoding matches the renderer's 5-bit orientation input.

---
 rtl/orientation_finder.sv | 226 ++++++++++++++++++++++
 tb/tb_orientation_finder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/orientation_finder.sv
// Recovers rover position and heading from a camera pixel stream: per-frame colour
// centroids of the body and heading indicator, quantised to 24 headings of 15 degrees.
module orientation_finder #(
    parameter logic [23:0] COLOR           = 24'hFF_FF_FF,
    parameter logic [23:0] INDICATOR_COLOR = 24'h00_FF_00,
    parameter int          TOL             = 16,
    parameter int          MIN_PIXELS      = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pixel_valid,
    input  logic signed [11:0] x_value,
    input  logic signed [11:0] y_value,
    input  logic        [23:0] pixel,
    input  logic               frame_end,
    output logic signed [11:0] center_x,
    output logic signed [11:0] center_y,
    output logic        [4:0]  orientation,
    output logic               found,
    output logic               orientation_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [2:0] {ACCUM, LATCH, DIV, ANGLE1, ANGLE2, OUT} state_t;

    localparam logic [8:0]  TOL_L = 9'(TOL);
    localparam logic [19:0] MIN_L = 20'(MIN_PIXELS);
    localparam logic [8:0]  TANS [6] = '{9'd8, 9'd27, 9'd49, 9'd83, 9'd155, 9'd486};

    function automatic logic ch_ok(input logic [7:0] p, input logic [7:0] t);
        logic [7:0] d;
        d = (p > t) ? (p - t) : (t - p);
        return {1'b0, d} <= TOL_L;
    endfunction

    function automatic logic color_match(input logic [23:0] p, input logic [23:0] t);
        return ch_ok(p[23:16], t[23:16]) && ch_ok(p[15:8], t[15:8]) && ch_ok(p[7:0], t[7:0]);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] s, input logic [10:0] v);
        logic [32:0] t;
        t = {1'b0, s} + {22'd0, v};
        return t[32] ? '1 : t[31:0];
    endfunction

    function automatic logic [19:0] sat_inc(input logic [19:0] c);
        return (c == '1) ? c : c + 20'd1;
    endfunction

    // Classification; class 0 is the body, class 1 the indicator
    logic       in_range, is_ind, is_body, drop;
    logic [1:0] hit;
    assign in_range = pixel_valid && !x_value[11] && !y_value[11];
    assign is_ind   = in_range && color_match(pixel, INDICATOR_COLOR);
    assign is_body  = in_range && !is_ind && color_match(pixel, COLOR);
    assign hit      = {is_ind, is_body};

    state_t      state_q;
    logic [19:0] cnt_q [2], cnt_d [2], snap_cnt_q [2];
    logic [31:0] sx_q [2], sx_d [2], snap_sx_q [2];
    logic [31:0] sy_q [2], sy_d [2], snap_sy_q [2];

    always_comb begin
        drop = frame_end && (state_q != ACCUM);
        for (int c = 0; c < 2; c++) begin
            cnt_d[c] = (state_q == LATCH) ? '0 : cnt_q[c];
            sx_d[c]  = (state_q == LATCH) ? '0 : sx_q[c];
            sy_d[c]  = (state_q == LATCH) ? '0 : sy_q[c];
            if (hit[c]) begin
                cnt_d[c] = sat_inc(cnt_d[c]);
                sx_d[c]  = sat_add(sx_d[c], x_value[10:0]);
                sy_d[c]  = sat_add(sy_d[c], y_value[10:0]);
            end
            if (drop) begin
                cnt_d[c] = '0;
                sx_d[c]  = '0;
                sy_d[c]  = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                cnt_q[c] <= '0; sx_q[c] <= '0; sy_q[c] <= '0;
                snap_cnt_q[c] <= '0; snap_sx_q[c] <= '0; snap_sy_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                cnt_q[c] <= cnt_d[c];
                sx_q[c]  <= sx_d[c];
                sy_q[c]  <= sy_d[c];
                if (state_q == LATCH) begin
                    snap_cnt_q[c] <= cnt_q[c];
                    snap_sx_q[c]  <= sx_q[c];
                    snap_sy_q[c]  <= sy_q[c];
                end
            end
        end
    end

    // Restoring divider: the upper 20 dividend bits seed the remainder, then 12 bits shift in
    logic [1:0]  div_sel_q;
    logic [3:0]  bit_cnt_q;
    logic [19:0] rem_q, rem_in, rem_next, dvs;
    logic [11:0] quo_q, quo_next, div_result, dvd_lo;
    logic [31:0] dvd;
    logic [20:0] shifted;
    logic        ovf_q, ovf_now, ge;
    logic [11:0] res_q [4];

    always_comb begin
        dvd      = div_sel_q[0] ? snap_sy_q[div_sel_q[1]] : snap_sx_q[div_sel_q[1]];
        dvs      = snap_cnt_q[div_sel_q[1]];
        dvd_lo   = dvd[11:0];
        rem_in   = (bit_cnt_q == 4'd0) ? dvd[31:12] : rem_q;
        ovf_now  = (bit_cnt_q == 4'd0) ? (dvd[31:12] >= dvs) : ovf_q;
        shifted  = {rem_in, dvd_lo[4'd11 - bit_cnt_q]};
        ge       = shifted >= {1'b0, dvs};
        rem_next = ge ? 20'(shifted - {1'b0, dvs}) : shifted[19:0];
        quo_next = {quo_q[10:0], ge};
        if (dvs == '0)   div_result = '0;
        else if (ovf_now) div_result = 12'h7FF;
        else             div_result = quo_next;
    end

    // Heading quantisation from |dx|, |dy| and their signs
    logic signed [12:0] dx_c, dy_c;
    logic        [12:0] a_q, b_q;
    logic               dx_neg_q, dy_neg_q, zero_q;
    logic        [2:0]  k_c;
    logic        [4:0]  orient_c, orient_calc_q;
    logic               found_v;

    always_comb begin
        dx_c = {res_q[2][11], res_q[2]} - {res_q[0][11], res_q[0]};
        dy_c = {res_q[3][11], res_q[3]} - {res_q[1][11], res_q[1]};
        k_c  = '0;
        for (int i = 0; i < 6; i++)
            if ((23'(b_q) << 6) > 23'(a_q) * 23'(TANS[i])) k_c = k_c + 3'd1;
        case ({dx_neg_q, dy_neg_q})
            2'b00:   orient_c = {2'b00, k_c};
            2'b10:   orient_c = 5'd12 - {2'b00, k_c};
            2'b11:   orient_c = 5'd12 + {2'b00, k_c};
            default: orient_c = (k_c == 3'd0) ? 5'd0 : 5'd24 - {2'b00, k_c};
        endcase
        found_v = (snap_cnt_q[0] >= MIN_L) && (snap_cnt_q[1] >= MIN_L) && !zero_q;
    end

    logic signed [11:0] center_x_q, center_y_q;
    logic        [4:0]  orientation_q;
    logic               found_q, valid_q, busy_q, overrun_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACCUM;
            div_sel_q <= '0; bit_cnt_q <= '0; rem_q <= '0; quo_q <= '0; ovf_q <= 1'b0;
            for (int r = 0; r < 4; r++) res_q[r] <= '0;
            a_q <= '0; b_q <= '0; dx_neg_q <= 1'b0; dy_neg_q <= 1'b0; zero_q <= 1'b0;
            orient_calc_q <= '0;
            center_x_q <= '0; center_y_q <= '0; orientation_q <= '0;
            found_q <= 1'b0; valid_q <= 1'b0; busy_q <= 1'b0; overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= drop;
            case (state_q)
                ACCUM: if (frame_end) begin
                    state_q <= LATCH;
                    busy_q  <= 1'b1;
                end
                LATCH: begin
                    div_sel_q <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= DIV;
                end
                DIV: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    ovf_q <= ovf_now;
                    if (bit_cnt_q == 4'd11) begin
                        res_q[div_sel_q] <= div_result;
                        bit_cnt_q <= '0;
                        div_sel_q <= div_sel_q + 2'd1;
                        if (div_sel_q == 2'd3) state_q <= ANGLE1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                ANGLE1: begin
                    a_q      <= dx_c[12] ? 13'(-dx_c) : 13'(dx_c);
                    b_q      <= dy_c[12] ? 13'(-dy_c) : 13'(dy_c);
                    dx_neg_q <= dx_c[12];
                    dy_neg_q <= dy_c[12];
                    zero_q   <= (dx_c == '0) && (dy_c == '0);
                    state_q  <= ANGLE2;
                end
                ANGLE2: begin
                    orient_calc_q <= orient_c;
                    state_q       <= OUT;
                end
                OUT: begin
                    valid_q <= 1'b1;
                    found_q <= found_v;
                    if (found_v) begin
                        center_x_q    <= res_q[0];
                        center_y_q    <= res_q[1];
                        orientation_q <= orient_calc_q;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ACCUM;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign center_x          = center_x_q;
    assign center_y          = center_y_q;
    assign orientation       = orientation_q;
    assign found             = found_q;
    assign orientation_valid = valid_q;
    assign busy              = busy_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_orientation_finder.sv
// Directed testbench for orientation_finder: draws marker rectangles, closes frames and
// compares the strobed result against hand-computed centroids and headings.
module tb_orientation_finder;

    localparam logic [23:0] W = 24'hFF_FF_FF;
    localparam logic [23:0] G = 24'h00_FF_00;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               pixel_valid = 1'b0;
    logic signed [11:0] x_value = '0;
    logic signed [11:0] y_value = '0;
    logic        [23:0] pixel = '0;
    logic               frame_end = 1'b0;
    logic signed [11:0] center_x, center_y;
    logic        [4:0]  orientation;
    logic               found, orientation_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    int                 g_lat, g_strobes, g_busy, g_ovr;
    logic signed [11:0] g_cx, g_cy;
    logic        [4:0]  g_or;
    logic               g_found;

    always #5 clock = ~clock;

    orientation_finder dut (
        .clock(clock), .reset_n(reset_n), .pixel_valid(pixel_valid),
        .x_value(x_value), .y_value(y_value), .pixel(pixel), .frame_end(frame_end),
        .center_x(center_x), .center_y(center_y), .orientation(orientation),
        .found(found), .orientation_valid(orientation_valid), .busy(busy), .overrun(overrun)
    );

    task automatic put_pix(input int x, input int y, input logic [23:0] c);
        @(negedge clock);
        pixel_valid = 1'b1;
        x_value = 12'(x);
        y_value = 12'(y);
        pixel = c;
    endtask

    task automatic rect(input int x0, input int y0, input int w, input int h, input logic [23:0] c);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                put_pix(x0 + i, y0 + j, c);
    endtask

    // Closes the frame (optionally with a pixel) and watches 60 cycles; fe2_at re-pulses frame_end
    task automatic run_frame(input logic fe_pv, input int fx, input int fy,
                             input logic [23:0] fc, input int fe2_at);
        @(negedge clock);
        frame_end = 1'b1;
        pixel_valid = fe_pv;
        x_value = 12'(fx);
        y_value = 12'(fy);
        pixel = fc;
        g_lat = -1; g_strobes = 0; g_busy = 0; g_ovr = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            frame_end = (n == fe2_at);
            pixel_valid = 1'b0;
            if (busy) g_busy++;
            if (overrun) g_ovr++;
            if (orientation_valid) begin
                g_strobes++;
                g_lat = n;
                g_cx = center_x; g_cy = center_y; g_or = orientation; g_found = found;
            end
        end
        frame_end = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({center_x, center_y, orientation, found, orientation_valid, busy, overrun} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0",
                {center_x, center_y, orientation, found, orientation_valid, busy, overrun});
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        rect(100, 200, 8, 8, W);
        rect(120, 202, 4, 4, G);
        run_frame(1'b0, 0, 0, W, -1);
        checks++; if (g_lat !== 52) begin errors++; $display("FAIL basic_latency got %0d want 52", g_lat); end
        checks++; if (g_strobes !== 1) begin errors++; $display("FAIL basic_strobes got %0d want 1", g_strobes); end
        checks++; if (g_found !== 1'b1) begin errors++; $display("FAIL basic_found got %b want 1", g_found); end
        checks++; if (g_cx !== 12'sd103) begin errors++; $display("FAIL basic_cx got %0d want 103", g_cx); end
        checks++; if (g_cy !== 12'sd203) begin errors++; $display("FAIL basic_cy got %0d want 203", g_cy); end
        checks++; if (g_or !== 5'd0) begin errors++; $display("FAIL basic_orient got %0d want 0", g_or); end
    endtask

    task automatic test_quadrants();
        rect(100, 200, 8, 8, W);
        rect(92, 212, 4, 4, G);
        run_frame(1'b0, 0, 0, W, -1);
        checks++; if (g_or !== 5'd9) begin errors++; $display("FAIL quad_nw_orient got %0d want 9", g_or); end
        checks++; if (g_busy !== 52) begin errors++; $display("FAIL quad_busy_cycles got %0d want 52", g_busy); end
        checks++; if (g_found !== 1'b1) begin errors++; $display("FAIL quad_nw_found got %b want 1", g_found); end
        rect(100, 200, 8, 8, W);
        rect(107, 182, 4, 4, G);
        run_frame(1'b0, 0, 0, W, -1);
        checks++; if (g_or !== 5'd19) begin errors++; $display("FAIL quad_se_orient got %0d want 19", g_or); end
        rect(100, 200, 8, 8, W);
        rect(102, 232, 4, 4, G);
        run_frame(1'b0, 0, 0, W, -1);
        checks++; if (g_or !== 5'd6) begin errors++; $display("FAIL quad_vert_orient got %0d want 6", g_or); end
    endtask

    task automatic test_min_pixels();
        rect(300, 200, 8, 8, W);
        rect(120, 203, 10, 1, G);
        run_frame(1'b0, 0, 0, W, -1);
        checks++; if (g_strobes !== 1) begin errors++; $display("FAIL min_strobes got %0d want 1", g_strobes); end
        checks++; if (g_found !== 1'b0) begin errors++; $display("FAIL min_found got %b want 0", g_found); end
        checks++; if (g_cx !== 12'sd103) begin errors++; $display("FAIL min_hold_cx got %0d want 103", g_cx); end
        checks++; if (g_cy !== 12'sd203) begin errors++; $display("FAIL min_hold_cy got %0d want 203", g_cy); end
        checks++; if (g_or !== 5'd6) begin errors++; $display("FAIL min_hold_orient got %0d want 6", g_or); end
    endtask

    task automatic test_overrun();
        rect(100, 200, 8, 8, W);
        rect(120, 202, 4, 4, G);
        run_frame(1'b0, 0, 0, W, 19);
        checks++; if (g_ovr !== 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", g_ovr); end
        checks++; if (g_strobes !== 1) begin errors++; $display("FAIL ovr_strobes got %0d want 1", g_strobes); end
        checks++; if (g_lat !== 52) begin errors++; $display("FAIL ovr_latency got %0d want 52", g_lat); end
        checks++; if (g_or !== 5'd0) begin errors++; $display("FAIL ovr_first_orient got %0d want 0", g_or); end
        rect(100, 200, 8, 8, W);
        rect(92, 212, 4, 4, G);
        run_frame(1'b0, 0, 0, W, -1);
        checks++; if (g_found !== 1'b1) begin errors++; $display("FAIL ovr_third_found got %b want 1", g_found); end
        checks++; if (g_or !== 5'd9) begin errors++; $display("FAIL ovr_third_orient got %0d want 9", g_or); end
        checks++; if (g_cx !== 12'sd103) begin errors++; $display("FAIL ovr_third_cx got %0d want 103", g_cx); end
    endtask

    task automatic test_tolerance();
        rect(100, 200, 8, 8, 24'hEF_EF_EF);
        rect(120, 202, 4, 4, 24'h10_EF_10);
        rect(500, 500, 4, 4, 24'h11_FF_00);
        rect(400, 400, 4, 4, 24'hFF_FF_EE);
        rect(-8, 200, 4, 4, W);
        run_frame(1'b0, 0, 0, W, -1);
        checks++; if (g_found !== 1'b1) begin errors++; $display("FAIL tol_found got %b want 1", g_found); end
        checks++; if (g_cx !== 12'sd103) begin errors++; $display("FAIL tol_cx got %0d want 103", g_cx); end
        checks++; if (g_cy !== 12'sd203) begin errors++; $display("FAIL tol_cy got %0d want 203", g_cy); end
        checks++; if (g_or !== 5'd0) begin errors++; $display("FAIL tol_orient got %0d want 0", g_or); end
    endtask

    task automatic test_frame_end_pixel();
        rect(100, 200, 8, 8, W);
        rect(120, 202, 4, 3, G);
        rect(120, 205, 3, 1, G);
        run_frame(1'b1, 123, 205, G, -1);
        checks++; if (g_found !== 1'b1) begin errors++; $display("FAIL fe_pixel_found got %b want 1", g_found); end
        checks++; if (g_or !== 5'd0) begin errors++; $display("FAIL fe_pixel_orient got %0d want 0", g_or); end
    endtask

    task automatic test_reset_during_div();
        int strobes;
        rect(100, 200, 8, 8, W);
        rect(92, 212, 4, 4, G);
        @(negedge clock);
        frame_end = 1'b1;
        pixel_valid = 1'b0;
        @(negedge clock);
        frame_end = 1'b0;
        repeat (20) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if ({center_x, center_y, orientation, found, orientation_valid, busy, overrun} !== '0) begin
            errors++; $display("FAIL rst_div_outputs got %h want 0",
                {center_x, center_y, orientation, found, orientation_valid, busy, overrun});
        end
        @(negedge clock);
        reset_n = 1'b1;
        strobes = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (orientation_valid) strobes++;
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL rst_div_strobes got %0d want 0", strobes); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_quadrants();
        test_min_pixels();
        test_overrun();
        test_tolerance();
        test_frame_end_pixel();
        test_reset_during_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
